// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a single-ported 64-bit data memory.
// Each accepted request becomes one memory strobe and a one-cycle response pulse, or a fault response.
module load_store_unit #(
  parameter int DEPTH_WORDS = 32,
  parameter int FCNT_W      = 8
) (
  input  logic              im_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              resp_valid,
  output logic [63:0]       resp_data,
  output logic              resp_fault,
  output logic              stall,
  output logic [FCNT_W-1:0] fault_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 3;

  state_e              state_q, state_d;
  logic [60:0]         word_q;
  logic [63:0]         wdata_q;
  logic                load_q;
  logic                store_q;
  logic [63:0]         resp_data_q;
  logic                resp_fault_q;
  logic [FCNT_W-1:0]   fault_count_q;

  logic                accept;
  logic                req_fault;

  assign accept = (state_q == IDLE) && req_valid;

  // Rejects ambiguous commands, sub-word addresses and anything past the last word.
  assign req_fault = (req_read == req_write)
                  || (req_addr[2:0] != 3'b000)
                  || (req_addr >= ADDR_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_fault ? RESP : ISSUE;
      ISSUE:   state_d = load_q ? CAPTURE : RESP;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      word_q        <= '0;
      wdata_q       <= '0;
      load_q        <= 1'b0;
      store_q       <= 1'b0;
      resp_data_q   <= '0;
      resp_fault_q  <= 1'b0;
      fault_count_q <= '0;
    end else begin
      if (accept) begin
        word_q  <= req_addr[63:3];
        wdata_q <= req_wdata;
        load_q  <= req_read;
        store_q <= req_write;
      end

      if (accept && req_fault && (fault_count_q != {FCNT_W{1'b1}})) begin
        fault_count_q <= fault_count_q + FCNT_W'(1);
      end

      // Response registers change only on entry to RESP and hold afterwards.
      if (accept && req_fault) begin
        resp_data_q  <= '0;
        resp_fault_q <= 1'b1;
      end else if ((state_q == ISSUE) && store_q) begin
        resp_data_q  <= '0;
        resp_fault_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
        resp_data_q  <= mem_rdata;
        resp_fault_q <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_read  = load_q;
        mem_write = store_q;
        mem_addr  = {3'b000, word_q};
        mem_wdata = wdata_q;
      end
      CAPTURE: ;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign stall       = ~req_ready;
  assign resp_data   = resp_data_q;
  assign resp_fault  = resp_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: an array-backed memory reference predicts every response.
module tb_load_store_unit;

  localparam int DEPTH = 32;
  localparam int FCNT_MAX = 255;

  logic        im_clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_read, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_fault, stall;
  logic [63:0] resp_data;
  logic [7:0]  fault_count;

  logic [63:0] tb_mem  [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  int          ref_fcount;
  logic [63:0] ref_last_data;
  logic        ref_last_fault;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .FCNT_W(8)) dut (
    .im_clk      (im_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_fault  (resp_fault),
    .stall       (stall),
    .fault_count (fault_count)
  );

  always #5 im_clk = ~im_clk;

  // Downstream memory: registers read data on the strobe edge.
  always @(posedge im_clk) begin
    if (mem_write) tb_mem[mem_addr[4:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= tb_mem[mem_addr[4:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    64'(mem_read), 64'd0);
    check({tag, "_wr"},    64'(mem_write), 64'd0);
    check({tag, "_maddr"}, mem_addr, 64'd0);
    check({tag, "_mwd"},   mem_wdata, 64'd0);
    check({tag, "_rv"},    64'(resp_valid), 64'd0);
    check({tag, "_rf"},    64'(resp_fault), 64'd0);
    check({tag, "_rdata"}, resp_data, 64'd0);
    check({tag, "_fcnt"},  64'(fault_count), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  // Entered and left just after a rising edge with the unit idle.
  task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata);
    bit          fault;
    int          lat, resp_cyc, strobe_cyc, nstrobe, bus_bad;
    logic        s_rd, s_wr, r_fault;
    logic [63:0] s_addr, s_wd, r_data, exp_data;

    fault = (rd == wr) || (addr[2:0] != 3'b000) || (addr >= 64'(DEPTH * 8));
    lat   = fault ? 1 : (wr ? 2 : 3);
    exp_data = (fault || wr) ? 64'd0 : ref_mem[addr[7:3]];
    if (!fault && wr) ref_mem[addr[7:3]] = wdata;
    if (fault && ref_fcount < FCNT_MAX) ref_fcount++;
    ref_last_data  = exp_data;
    ref_last_fault = fault;

    req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    check("ready_idle", 64'(req_ready), 64'd1);
    @(posedge im_clk); #1;
    req_valid = 1'b0;

    resp_cyc = -1; strobe_cyc = -1; nstrobe = 0; bus_bad = 0;
    s_rd = 0; s_wr = 0; s_addr = '0; s_wd = '0; r_data = '0; r_fault = 0;
    for (int cyc = 1; cyc <= 6 && resp_cyc < 0; cyc++) begin
      if (mem_read || mem_write) begin
        nstrobe += int'(mem_read) + int'(mem_write);
        strobe_cyc = cyc;
        s_rd = mem_read; s_wr = mem_write; s_addr = mem_addr; s_wd = mem_wdata;
      end else if (mem_addr != 0 || mem_wdata != 0) begin
        bus_bad++;
      end
      check("stall_busy", 64'(stall), 64'd1);
      if (resp_valid) begin
        resp_cyc = cyc; r_data = resp_data; r_fault = resp_fault;
      end
      @(posedge im_clk); #1;
    end

    check("latency", 64'(resp_cyc), 64'(lat));
    check("strobes", 64'(nstrobe), fault ? 64'd0 : 64'd1);
    check("bus_idle", 64'(bus_bad), 64'd0);
    if (!fault) begin
      check("strobe_cyc", 64'(strobe_cyc), 64'd1);
      check("strobe_rd", 64'(s_rd), 64'(rd));
      check("strobe_wr", 64'(s_wr), 64'(wr));
      check("mem_addr", s_addr, addr >> 3);
      check("mem_wdata", s_wd, wdata);
    end
    check("resp_data", r_data, exp_data);
    check("resp_fault", 64'(r_fault), 64'(fault));
    check("fault_count", 64'(fault_count), 64'(ref_fcount));
    check("resp_pulse", 64'(resp_valid), 64'd0);
    check("resp_hold", resp_data, exp_data);
    check("fault_hold", 64'(resp_fault), 64'(fault));
  endtask

  task automatic hold_test();
    int          w, nstr;
    logic [63:0] exp;
    w   = $urandom_range(0, DEPTH - 1);
    exp = ref_mem[w];
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_addr = 64'(w) << 3; req_wdata = {$urandom, $urandom};
    check("hold_ready", 64'(req_ready), 64'd1);
    @(posedge im_clk); #1;
    nstr = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      nstr += int'(mem_read) + int'(mem_write);
      check("hold_stall", 64'(stall), (cyc <= 3) ? 64'd1 : 64'd0);
      if (cyc == 3) begin
        check("hold_resp1", 64'(resp_valid), 64'd1);
        check("hold_data1", resp_data, exp);
      end
      @(posedge im_clk); #1;
    end
    check("hold_strobes", 64'(nstr), 64'd1);
    check("hold_reissue", 64'(mem_read), 64'd1);
    check("hold_addr2", mem_addr, 64'(w));
    req_valid = 1'b0;
    @(posedge im_clk); #1;
    @(posedge im_clk); #1;
    check("hold_resp2", 64'(resp_valid), 64'd1);
    check("hold_data2", resp_data, exp);
    @(posedge im_clk); #1;
  endtask

  // Aborts a load with reset in the given busy cycle (1=ISSUE, 2=CAPTURE, 3=RESP).
  task automatic reset_mid(input int at_cyc);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_addr = 64'($urandom_range(0, DEPTH - 1)) << 3; req_wdata = '0;
    @(posedge im_clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < at_cyc; c++) begin
      @(posedge im_clk); #1;
    end
    check("pre_rst_busy", 64'(stall), 64'd1);
    if (at_cyc == 1) check("pre_rst_strobe", 64'(mem_read), 64'd1);
    if (at_cyc == 3) check("pre_rst_resp", 64'(resp_valid), 64'd1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    ref_fcount = 0; ref_last_data = '0; ref_last_fault = 1'b0;
    @(posedge im_clk);
    @(posedge im_clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_noresp", 64'(resp_valid), 64'd0);
      check("post_rst_ready", 64'(req_ready), 64'd1);
      @(posedge im_clk); #1;
    end
  endtask

  initial begin
    logic [63:0] a;
    int          r, k;
    reset = 1'b1;
    req_valid = 0; req_read = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = {$urandom, $urandom};
      ref_mem[i] = tb_mem[i];
    end
    ref_fcount = 0;
    @(posedge im_clk);
    @(posedge im_clk); #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    do_req(1'b0, 1'b1, 64'h10, 64'hDEAD);
    do_req(1'b1, 1'b0, 64'h10, 64'h0);
    do_req(1'b1, 1'b0, 64'h0C, 64'h0);
    do_req(1'b1, 1'b0, 64'h100, 64'h0);
    do_req(1'b1, 1'b0, 64'hF8, 64'h0);
    do_req(1'b0, 1'b1, 64'hF8, 64'h1234_5678_9ABC_DEF0);
    do_req(1'b1, 1'b0, 64'hF8, 64'h0);
    do_req(1'b0, 1'b0, 64'h20, 64'h55);
    do_req(1'b1, 1'b1, 64'h20, 64'h55);
    do_req(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      if (k < 7)       a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      else if (k == 7) a = (64'($urandom_range(0, DEPTH - 1)) << 3) + 64'($urandom_range(1, 7));
      else if (k == 8) a = 64'(DEPTH * 8) + (64'($urandom_range(0, 1000)) << 3);
      else             a = {1'b1, 31'($urandom), $urandom};
      do_req(r == 8 || (r >= 0 && r < 4), r == 8 || (r >= 4 && r < 8), a, {$urandom, $urandom});
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(posedge im_clk); #1;
      end
    end

    for (int n = 0; n < 300; n++) begin
      do_req(1'b1, 1'b1, 64'($urandom_range(0, 255)), {$urandom, $urandom});
    end
    check("fcnt_saturated", 64'(fault_count), 64'd255);

    hold_test();
    reset_mid(2);
    do_req(1'b1, 1'b0, 64'h10, 64'h0);
    reset_mid(1);
    do_req(1'b0, 1'b1, 64'h18, {$urandom, $urandom});
    reset_mid(3);
    do_req(1'b1, 1'b0, 64'h18, 64'h0);
    do_req(1'b1, 1'b0, 64'h0C, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
